// File: rtl/wsa_adc_frontend.sv
// wsa_adc_frontend: receive-side ADC front end.
// Sign-extends two 12-bit ADC streams, removes a programmable DC offset per
// channel with saturation, routes the corrected samples to the DDC I/Q inputs
// and keeps per-channel signal-strength and overload statistics.
module wsa_adc_frontend #(
  parameter logic [6:0] ADDR_RX_MUX   = 7'd38,
  parameter logic [6:0] ADDR_OFFSET_A = 7'd46,
  parameter logic [6:0] ADDR_OFFSET_B = 7'd47
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic [11:0] rx_a_a,
  input  logic [11:0] rx_b_a,
  output logic [15:0] ddc0_in_i,
  output logic [15:0] ddc0_in_q,
  output logic [3:0]  rx_numchan,
  output logic [31:0] rssi_0,
  output logic [31:0] rssi_1
);

  localparam int DATA_W = 16;

  // Clamp a 17-bit difference into the signed 16-bit range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W:0] x);
    if (x[DATA_W] != x[DATA_W-1])
      return x[DATA_W] ? 16'sh8000 : 16'sh7FFF;
    else
      return x[DATA_W-1:0];
  endfunction

  // Absolute value; inputs are sign-extended 12-bit so -x never overflows.
  function automatic logic [DATA_W-1:0] mag16(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    return x[DATA_W-1] ? $unsigned(neg) : $unsigned(x);
  endfunction

  // Full-scale detect on the original 12-bit code range.
  function automatic logic is_ovf(input logic signed [DATA_W-1:0] x);
    return (x == 16'sh07FF) || (x == 16'shF800);
  endfunction

  logic [31:0]              mux_reg;
  logic signed [DATA_W-1:0] off_a, off_b;

  logic signed [DATA_W-1:0] a_p0, b_p0;
  logic signed [DATA_W-1:0] a_p1, b_p1;
  logic signed [DATA_W-1:0] i_p2, q_p2;
  logic signed [DATA_W:0]   diff_a, diff_b;

  logic [25:0] acc_a, acc_b;
  logic [25:0] oacc_a, oacc_b;

  logic unused_mux_bits;

  // Register bus: each write lands at the edge, so the sample in flight sees the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mux_reg <= 32'h0000_0022;
      off_a   <= '0;
      off_b   <= '0;
    end else if (serial_strobe) begin
      if (serial_addr == ADDR_RX_MUX)
        mux_reg <= serial_data;
      else if (serial_addr == ADDR_OFFSET_A)
        off_a <= serial_data[15:0];
      else if (serial_addr == ADDR_OFFSET_B)
        off_b <= serial_data[15:0];
    end
  end

  assign rx_numchan      = mux_reg[3:0];
  assign unused_mux_bits = ^mux_reg[31:7];

  // Offset subtraction at 17 bits so the saturation test sees the true result.
  always_comb begin
    diff_a = {a_p0[DATA_W-1], a_p0} - {off_a[DATA_W-1], off_a};
    diff_b = {b_p0[DATA_W-1], b_p0} - {off_b[DATA_W-1], off_b};
  end

  // Three-stage sample pipeline; every stage holds while enable is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_p0 <= '0;
      b_p0 <= '0;
      a_p1 <= '0;
      b_p1 <= '0;
      i_p2 <= '0;
      q_p2 <= '0;
    end else if (enable) begin
      // stage 1: sign-extend raw ADC codes
      a_p0 <= {{4{rx_a_a[11]}}, rx_a_a};
      b_p0 <= {{4{rx_b_a[11]}}, rx_b_a};
      // stage 2: DC offset removal with saturation
      a_p1 <= sat16(diff_a);
      b_p1 <= sat16(diff_b);
      // stage 3: I/Q routing
      i_p2 <= mux_reg[4] ? b_p1 : a_p1;
      if (mux_reg[6])
        q_p2 <= '0;
      else
        q_p2 <= mux_reg[5] ? b_p1 : a_p1;
    end
  end

  assign ddc0_in_i = i_p2;
  assign ddc0_in_q = q_p2;

  // Leaky integrators (time constant 1024 samples) on stage-1 magnitude and overload flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_a  <= '0;
      acc_b  <= '0;
      oacc_a <= '0;
      oacc_b <= '0;
    end else if (enable) begin
      acc_a  <= acc_a + {10'd0, mag16(a_p0)} - (acc_a >> 10);
      acc_b  <= acc_b + {10'd0, mag16(b_p0)} - (acc_b >> 10);
      oacc_a <= oacc_a + (is_ovf(a_p0) ? 26'd1024 : 26'd0) - (oacc_a >> 10);
      oacc_b <= oacc_b + (is_ovf(b_p0) ? 26'd1024 : 26'd0) - (oacc_b >> 10);
    end
  end

  assign rssi_0 = {oacc_a[25:10], acc_a[25:10]};
  assign rssi_1 = {oacc_b[25:10], acc_b[25:10]};

endmodule

// File: tb/tb_wsa_adc_frontend.sv
// tb_wsa_adc_frontend: directed vector bench for wsa_adc_frontend.
module tb_wsa_adc_frontend;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic [11:0] rx_a_a;
  logic [11:0] rx_b_a;
  logic [15:0] ddc0_in_i;
  logic [15:0] ddc0_in_q;
  logic [3:0]  rx_numchan;
  logic [31:0] rssi_0;
  logic [31:0] rssi_1;

  int n_tests = 0;
  int n_fail  = 0;

  wsa_adc_frontend dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .rx_a_a        (rx_a_a),
    .rx_b_a        (rx_b_a),
    .ddc0_in_i     (ddc0_in_i),
    .ddc0_in_q     (ddc0_in_q),
    .rx_numchan    (rx_numchan),
    .rssi_0        (rssi_0),
    .rssi_1        (rssi_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] mux;
    logic [15:0] offa;
    logic [15:0] offb;
    logic [11:0] a;
    logic [11:0] b;
    logic [15:0] ei;
    logic [15:0] eq;
    logic [3:0]  enc;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [6:0] addr, input logic [31:0] data);
    serial_addr   = addr;
    serial_data   = data;
    serial_strobe = 1'b1;
    tick();
    serial_strobe = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    int d;
    n_tests++;
    d = act - exp;
    if (d < -tol || d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  initial begin
    // mux, offA, offB, A, B, expected I, expected Q, expected numchan
    vecs[0] = '{32'h22, 16'h0000, 16'h0000, 12'h123, 12'hF00, 16'h0123, 16'hFF00, 4'd2};
    vecs[1] = '{32'h13, 16'h0000, 16'h0000, 12'h123, 12'hF00, 16'hFF00, 16'h0123, 4'd3};
    vecs[2] = '{32'h22, 16'h0064, 16'h0000, 12'h1F4, 12'h000, 16'h0190, 16'h0000, 4'd2};
    vecs[3] = '{32'h22, 16'h8000, 16'h0000, 12'h7FF, 12'h000, 16'h7FFF, 16'h0000, 4'd2};
    vecs[4] = '{32'h22, 16'h0000, 16'h7FFF, 12'h000, 12'h800, 16'h0000, 16'h8000, 4'd2};
    vecs[5] = '{32'h62, 16'h0000, 16'h0000, 12'h123, 12'h456, 16'h0123, 16'h0000, 4'd2};
    vecs[6] = '{32'h22, 16'hFFFB, 16'h0007, 12'hFFF, 12'h007, 16'h0004, 16'h0000, 4'd2};
    vecs[7] = '{32'h1F, 16'h0000, 16'h0001, 12'h7FF, 12'h801, 16'hF800, 16'h07FF, 4'd15};

    reset = 1'b1; enable = 1'b0; serial_addr = '0; serial_data = '0;
    serial_strobe = 1'b0; rx_a_a = '0; rx_b_a = '0;
    repeat (3) tick();

    chk("rst_i", ddc0_in_i, 16'h0000);
    chk("rst_q", ddc0_in_q, 16'h0000);
    chk("rst_numchan", rx_numchan, 4'd2);
    chk("rst_rssi0", rssi_0, 32'h0);
    chk("rst_rssi1", rssi_1, 32'h0);

    reset  = 1'b0;
    enable = 1'b1;

    // table-driven routing / offset / saturation vectors
    for (int i = 0; i < 8; i++) begin
      rx_a_a = vecs[i].a;
      rx_b_a = vecs[i].b;
      wr(7'd38, vecs[i].mux);
      wr(7'd46, {16'h0, vecs[i].offa});
      wr(7'd47, {16'h0, vecs[i].offb});
      repeat (3) tick();
      chk($sformatf("vec%0d_i", i), ddc0_in_i, vecs[i].ei);
      chk($sformatf("vec%0d_q", i), ddc0_in_q, vecs[i].eq);
      chk($sformatf("vec%0d_numchan", i), rx_numchan, vecs[i].enc);
    end

    // write coinciding with a sample: old value used at that edge
    wr(7'd38, 32'h22);
    wr(7'd46, 32'h0);
    wr(7'd47, 32'h0);
    rx_a_a = 12'h100;
    rx_b_a = 12'h200;
    repeat (3) tick();
    chk("sim_base_i", ddc0_in_i, 16'h0100);
    wr(7'd38, 32'h13);
    chk("sim_mux_old", ddc0_in_i, 16'h0100);
    tick();
    chk("sim_mux_new", ddc0_in_i, 16'h0200);
    wr(7'd38, 32'h22);
    tick();
    wr(7'd46, 32'h10);
    chk("sim_off_e0", ddc0_in_i, 16'h0100);
    tick();
    chk("sim_off_e1", ddc0_in_i, 16'h0100);
    tick();
    chk("sim_off_e2", ddc0_in_i, 16'h00F0);

    // statistics convergence
    wr(7'd46, 32'h0);
    rx_a_a = 12'hED4;
    rx_b_a = 12'h7FF;
    repeat (20000) tick();
    chk_near("rssi0_mag", int'(rssi_0[15:0]), 300, 1);
    chk("rssi0_ovl", rssi_0[31:16], 16'h0000);
    chk_near("rssi1_ovl", int'(rssi_1[31:16]), 1024, 1);
    chk_near("rssi1_mag", int'(rssi_1[15:0]), 2047, 1);
    chk("stat_i", ddc0_in_i, 16'hFED4);
    chk("stat_q", ddc0_in_q, 16'h07FF);

    // enable hold
    enable = 1'b0;
    rx_a_a = 12'h000;
    rx_b_a = 12'h000;
    repeat (10) tick();
    chk("hold_i", ddc0_in_i, 16'hFED4);
    chk("hold_q", ddc0_in_q, 16'h07FF);
    chk_near("hold_rssi0", int'(rssi_0[15:0]), 300, 1);
    chk_near("hold_ovl1", int'(rssi_1[31:16]), 1024, 1);
    enable = 1'b1;
    repeat (2) tick();
    chk("resume_lat2_i", ddc0_in_i, 16'hFED4);
    tick();
    chk("resume_lat3_i", ddc0_in_i, 16'h0000);
    chk("resume_lat3_q", ddc0_in_q, 16'h0000);

    // asynchronous reset mid-stream
    wr(7'd38, 32'h1F);
    rx_a_a = 12'h123;
    rx_b_a = 12'h456;
    repeat (3) tick();
    chk("pre_rst_numchan", rx_numchan, 4'd15);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_i", ddc0_in_i, 16'h0000);
    chk("arst_q", ddc0_in_q, 16'h0000);
    chk("arst_numchan", rx_numchan, 4'd2);
    chk("arst_rssi0", rssi_0, 32'h0);
    chk("arst_rssi1", rssi_1, 32'h0);
    repeat (2) tick();
    reset = 1'b0;

    // unmapped address write on the first enabled clock after release
    wr(7'd45, 32'hFFFF_FFFF);
    tick();
    chk("post_lat2_i", ddc0_in_i, 16'h0000);
    tick();
    chk("post_lat3_i", ddc0_in_i, 16'h0123);
    chk("post_lat3_q", ddc0_in_q, 16'h0456);
    chk("addr45_numchan", rx_numchan, 4'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wsa_adc_frontend.md
Name: wsa_adc_frontend

Overview:
- Receive-side ADC front end for the WSA1000 top level.
- Takes two 12-bit ADC streams (A, B) on the ADC clock and sign-extends them to 16 bits.
- Subtracts a programmable DC offset per channel, then routes the results to the DDC I/Q inputs through a programmable mux.
- Reports received signal strength and overload statistics for readback over the serial register bus.

Parameters:
- ADDR_RX_MUX, 38: serial register address of the mux/channel-count register.
- ADDR_OFFSET_A, 46: address of channel A DC offset register.
- ADDR_OFFSET_B, 47: address of channel B DC offset register.

Ports:
- clock  in  1  ADC sample clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  sample pipeline / statistics enable.
- serial_addr  in  7  register bus address.
- serial_data  in  32  register bus write data.
- serial_strobe  in  1  register write strobe, one clock wide.
- rx_a_a  in  12  ADC A sample, two's complement.
- rx_b_a  in  12  ADC B sample, two's complement.
- ddc0_in_i  out  16  DDC I input.
- ddc0_in_q  out  16  DDC Q input.
- rx_numchan  out  4  configured receive channel count.
- rssi_0  out  32  {overload[15:0], rssi[15:0]} for ADC A.
- rssi_1  out  32  same statistics for ADC B.

Behaviour:
- Reset (async, active-high) forces the following; all other state is cleared to 0:
  - mux register = 32'h0000_0022;
  - both offsets = 0;
  - all pipeline registers, accumulators and outputs = 0.
- Register writes:
  - On a rising edge with serial_strobe=1, the register whose address equals serial_addr loads serial_data.
  - The new value takes effect from the next cycle; writes to other addresses are ignored.
  - Writes are accepted regardless of enable.
- Mux register fields:
  - [3:0] = rx_numchan, driven combinationally from the register.
  - [4] I source: 0=A, 1=B.
  - [5] Q source: 0=A, 1=B.
  - [6] zero_q: when 1, Q output is 0.
  - Other bits are stored but unused.
- Offset registers: signed 16-bit, taken from serial_data[15:0]; upper bits are ignored.
- Pipeline (advances only when enable=1; all stages hold when enable=0):
  - Stage 1: register rx_a_a/rx_b_a sign-extended to 16 bits.
  - Stage 2: corrected = stage1 − offset, computed at 17 bits and saturated to [−32768, 32767].
  - Stage 3: ddc0_in_i/ddc0_in_q registered from the mux selection.
  - Latency from input sample to ddc output: exactly 3 enabled clocks.
  - Mux or offset changes appear at the output 1–3 cycles after the write, depending on stage.
- RSSI per channel (updates only when enable=1, operating on stage-1 samples):
  - mag = |x| over 16 bits, where |−2048| = 2048.
  - acc (26-bit unsigned) <= acc + mag − (acc >> 10).
  - rssi = acc[25:10]; steady state with constant |x| = |x|.
- Overload per channel:
  - ovf = 1 when the stage-1 12-bit sample is 2047 or −2048.
  - oacc (26-bit) <= oacc + (ovf ? 1024 : 0) − (oacc >> 10).
  - overload = oacc[25:10]; converges to 1024 under continuous overload, 0 with none.
- Reset asserted mid-stream immediately zeroes outputs. After release, the first valid output appears on the 3rd enabled clock.
- Simultaneous write and sample: the sample in flight uses the old register value at that edge.

Test Plan:
- Reset defaults: after reset, check ddc0_in_i=0, ddc0_in_q=0, rx_numchan=2, rssi_0=rssi_1=0.
- Routing and latency: hold reset defaults, drive A=12'h123, B=12'hF00 with enable=1 → after 3 clocks I=16'h0123, Q=16'hFF00. Write mux=0x13 (I=B, Q=A, numchan=3) → I=16'hFF00, Q=16'h0123, rx_numchan=3.
- DC offset and saturation:
  - Write offset A=100, A=500 → I=400.
  - Write offset A=16'h8000 (−32768), A=2047 → I saturates to 32767.
  - Write offset B=32767, B=−2048 → Q saturates to −32768.
- zero_q: write mux=0x62 → Q=0 while I still tracks A.
- Enable hold: drop enable while changing inputs → outputs and rssi unchanged. Raise enable → new data appears after 3 clocks.
- Statistics:
  - Constant A=−300 for 20000 enabled clocks → rssi_0[15:0] within 1 of 300, rssi_0[31:16]=0.
  - Constant B=2047 for 20000 clocks → rssi_1[31:16] within 1 of 1024.
  - Address 45 writes leave all registers unchanged.
